// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the binary-to-BCD converter and 7-segment scanner.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package bcd_disp_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Smallest digit count d with 10**d >= 2**bin_w. Evaluated at elaboration
    // only; the 64-bit arithmetic limits it to bin_w <= 63.
    function automatic int min_digits(input int bin_w);
        longint unsigned lim;
        longint unsigned p;
        int              d;
        lim = 64'd1 << bin_w;
        p   = 64'd1;
        d   = 0;
        while (p < lim) begin
            p = p * 64'd10;
            d = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/seg7_digit_lut.sv
// Nibble to active-high 7-segment pattern; codes 10-15 decode to blank.
// Latency: combinational.
// Backpressure: none.
// Ports: i_nibble (4-bit digit code), o_seg ({g,f,e,d,c,b,a}, 1 = segment lit).
module seg7_digit_lut
    import bcd_disp_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_nibble)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bin2bcd_seg7_display.sv
// Serial shift-and-add-3 binary-to-BCD converter driving a scanned N-digit 7-segment display.
// Latency: bcd_valid pulses BIN_W cycles after the accept edge; one conversion per BIN_W+1 cycles.
// Backpressure: in_ready low while converting; in_valid is ignored then (nothing is queued).
// Ports: clk, rst_n (async active-low); in_valid/in_ready/bin_in request handshake;
//        bcd_out/bcd_valid latched result and update pulse; seg/an scanned display drive.
module bin2bcd_seg7_display
    import bcd_disp_pkg::*;
#(
    parameter int BIN_W          = 16,
    parameter int DIGITS         = 5,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bcd_valid,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int RW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int SW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    generate
        if (DIGITS < min_digits(BIN_W)) begin : g_err_digits
            $error("bin2bcd_seg7_display: DIGITS too small for BIN_W");
        end
        if (REFRESH_DIV < 1) begin : g_err_refresh
            $error("bin2bcd_seg7_display: REFRESH_DIV must be at least 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Converter FSM
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    logic                w_last;
    logic [CNT_W-1:0]    r_cnt;
    logic [WORK_W-1:0]   r_work;
    logic [WORK_W-1:0]   w_shift;
    logic [BCD_W-1:0]    r_bcd;
    logic                r_bcd_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == CNT_W'(BIN_W - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // One double-dabble step: correct every BCD nibble that would overflow
    // past 9 when doubled, then shift the next binary bit in.
    always_comb begin
        logic [WORK_W-1:0] v_adj;
        v_adj = r_work;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_work[BIN_W + 4*k +: 4] >= 4'd5) begin
                v_adj[BIN_W + 4*k +: 4] = r_work[BIN_W + 4*k +: 4] + 4'd3;
            end
        end
        w_shift = v_adj << 1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work    <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_bcd_vld <= 1'b0;
        end else begin
            r_bcd_vld <= w_last;
            if (w_accept) begin
                r_work <= {{BCD_W{1'b0}}, bin_in};
                r_cnt  <= '0;
            end else if (r_state == SHIFT) begin
                r_work <= w_shift;
                r_cnt  <= r_cnt + 1'b1;
            end
            // Only the finished value reaches the display register.
            if (w_last) begin
                r_bcd <= w_shift[WORK_W-1 -: BCD_W];
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign bcd_out   = r_bcd;
    assign bcd_valid = r_bcd_vld;

    // ------------------------------------------------------------------
    // Display scan: free-running, independent of conversions
    // ------------------------------------------------------------------
    logic [RW-1:0] r_ref;
    logic [SW-1:0] r_scan;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref  <= '0;
            r_scan <= '0;
        end else if (r_ref == RW'(REFRESH_DIV - 1)) begin
            r_ref  <= '0;
            r_scan <= (r_scan == SW'(DIGITS - 1)) ? '0 : r_scan + 1'b1;
        end else begin
            r_ref <= r_ref + 1'b1;
        end
    end

    logic [DIGITS-1:0] w_blank;
    logic [3:0]        w_nib;
    logic              w_cur_blank;
    logic [DIGITS-1:0] w_an_hi;
    logic [6:0]        w_lut_seg;
    logic [6:0]        w_seg_hi;

    always_comb begin
        logic v_zero_above;
        // Leading-zero blanking walks down from the top digit; digit 0 always shows.
        w_blank      = '0;
        v_zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            v_zero_above = v_zero_above & (r_bcd[4*i +: 4] == 4'd0);
            w_blank[i]   = v_zero_above;
        end
        w_nib       = '0;
        w_cur_blank = 1'b0;
        w_an_hi     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scan == SW'(i)) begin
                w_nib       = r_bcd[4*i +: 4];
                w_cur_blank = w_blank[i];
                w_an_hi[i]  = 1'b1;
            end
        end
    end

    seg7_digit_lut u_lut (
        .i_nibble (w_nib),
        .o_seg    (w_lut_seg)
    );

    // A blanked digit keeps its enable slot but lights nothing.
    assign w_seg_hi = w_cur_blank ? SEG_BLANK : w_lut_seg;
    assign seg      = (SEG_ACTIVE_LOW != 0) ? ~w_seg_hi : w_seg_hi;
    assign an       = (SEG_ACTIVE_LOW != 0) ? ~w_an_hi  : w_an_hi;

endmodule
